// File: rtl/seq_multiplier_if.sv
// Handshake and result bundle for the sequential shift-and-add multiplier.
// The master drives the operands and start; the slave returns status and the product.
interface seq_multiplier_if #(
    parameter int N = 8
);
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] result;
    logic           zero;
    logic           overflow;

    modport master (
        output start, a, b,
        input  busy, done, result, zero, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, zero, overflow
    );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned N x N shift-and-add multiplier with a fixed N-cycle calculation phase.
// A registered 2N-bit product is published for one DONE cycle and held until the next.
module seq_multiplier #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_multiplier_if.slave  bus
);
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [2*N-1:0]   mcand;
    logic [N-1:0]     mplier;
    logic [2*N-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0]   result_q;
    logic [2*N-1:0]   acc_next;

    // One partial-product step; the sum wraps modulo 2^(2N) by construction.
    function automatic logic [2*N-1:0] add_partial(
        input logic [2*N-1:0] acc_in,
        input logic [2*N-1:0] mcand_in,
        input logic           bit_in
    );
        return bit_in ? (acc_in + mcand_in) : acc_in;
    endfunction

    always_comb begin
        acc_next = add_partial(acc, mcand, mplier[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= {{N{1'b0}}, bus.a};
                        mplier <= bus.b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    // Last step: the product leaves in the same edge that enters DONE.
                    if (cnt == CNT_W'(N - 1)) begin
                        result_q <= acc_next;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (state == CALC) || (state == DONE);
    assign bus.done     = (state == DONE);
    assign bus.result   = result_q;
    assign bus.zero     = (result_q == '0);
    assign bus.overflow = |result_q[2*N-1:N];
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomized bench for seq_multiplier (N=8) against a plain a*b reference.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_seq_multiplier;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    seq_multiplier_if #(.N(N)) bus ();

    seq_multiplier #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One accepted operation; 'junk' cycles after acceptance keep start high with
    // unrelated operands, which must neither disturb nor re-launch the operation.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input int junk);
        logic [2*N-1:0] prod;
        logic [2*N-1:0] prev;
        logic [2*N-1:0] res_done;
        int done_cnt;
        int done_at;
        int busy_cnt;
        prod     = (2*N)'(ta) * (2*N)'(tb);
        done_cnt = 0;
        done_at  = -1;
        busy_cnt = 0;
        res_done = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb;
        prev      = bus.result;
        for (int c = 1; c <= N + 1; c++) begin
            @(negedge clk);
            if (c <= junk) begin
                bus.start = 1'b1;
                bus.a     = N'($urandom);
                bus.b     = N'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_at  = c;
                res_done = bus.result;
            end else begin
                check("result_hold", 64'(bus.result), 64'(prev));
            end
        end
        check("done_count", 64'(done_cnt), 64'(1));
        check("done_latency", 64'(done_at), 64'(N + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(N + 1));
        check("result", 64'(res_done), 64'(prod));
        check("zero", 64'(bus.zero), 64'(prod == '0));
        check("overflow", 64'(bus.overflow), 64'(prod[2*N-1:N] != '0));
        @(negedge clk);
        check("idle_busy", 64'(bus.busy), 64'(0));
        check("idle_done", 64'(bus.done), 64'(0));
        check("idle_result", 64'(bus.result), 64'(prod));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_done"}, 64'(bus.done), 64'(0));
        check({tag, "_result"}, 64'(bus.result), 64'(0));
        check({tag, "_zero"}, 64'(bus.zero), 64'(1));
        check({tag, "_overflow"}, 64'(bus.overflow), 64'(0));
    endtask

    initial begin
        int done_seen;
        int last_done;
        int first_done;
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'h77;
        bus.b     = 8'h33;

        // Reset with start held high: start must be ignored.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("post_reset_busy", 64'(bus.busy), 64'(0));

        run_op(8'h0F, 8'h0F, 0);
        run_op(8'hFF, 8'hFF, 0);
        run_op(8'h00, 8'h55, 0);
        run_op(8'h12, 8'h34, 4);

        // Abort an operation in its 4th CALC cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("abort");
        done_seen = 0;
        for (int c = 0; c < 2 * N; c++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'(0));
        run_op(8'h03, 8'h05, 0);

        // Continuous start: one operation every N+2 cycles.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = 8'h02;
        bus.b      = 8'h80;
        done_seen  = 0;
        last_done  = -1;
        first_done = -1;
        for (int c = 1; c <= 5 * (N + 2); c++) begin
            @(negedge clk);
            if (bus.done) begin
                done_seen++;
                if (last_done >= 0) check("stream_period", 64'(c - last_done), 64'(N + 2));
                else first_done = c;
                last_done = c;
                check("stream_result", 64'(bus.result), 64'h0100);
                check("stream_overflow", 64'(bus.overflow), 64'(1));
            end else if (first_done >= 0) begin
                check("stream_hold", 64'(bus.result), 64'h0100);
            end
        end
        check("stream_count", 64'(done_seen >= 4), 64'(1));
        bus.start = 1'b0;
        repeat (N + 3) @(negedge clk);

        // Randomized operands with occasional start noise during the operation.
        for (int i = 0; i < 24; i++) begin
            run_op(N'($urandom), N'($urandom), int'($urandom_range(0, 4)));
        end
        run_op(8'hFF, 8'h01, 0);
        run_op(8'h01, 8'h00, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
